thread_loader: RTL and testbench
================================

THREAD_LOADER -- requirements
Module: thread_loader

Parameters
REQ-001 CODE_DEPTH, default 16; number of code slots in my_pkg::thread_type; legal code lengths are 0..CODE_DEPTH.
REQ-002 NUM_REGS, default 16; number of data registers in my_pkg::thread_type.
REQ-003 DATA_W, default 32; width of each data register and of both stream words.

Interface
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid / in_ready / in_data[DATA_W-1:0] / in_last  in/out/in/in; load stream, valid-ready handshake.
REQ-007 exe_thread  output  my_pkg::thread_type  thread presented to the execution stage.
REQ-008 exe_instr  output  8  program counter presented to the execution stage.
REQ-009 exe_result  input  my_pkg::thread_type  registered thread returned by the execution stage one cycle after issue.
REQ-010 exe_instr_post  input  8  registered exe_instr+1 returned by the execution stage.
REQ-011 out_valid / out_ready / out_data[DATA_W-1:0] / out_last  out/in/out/out; result stream, valid-ready handshake.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 err  output  1  sticky framing-error flag; cleared only by rst or by an accepted header.

Function
REQ-014 A transfer occurs when valid and ready are both high on a clock edge.
REQ-015 FSM states: IDLE, HDR, CODE, DATA, ISSUE, CAPT, DRAIN.
REQ-016 IDLE: in_ready=1; the first accepted word is the header. The block moves to CODE if L>0, else to DATA.
REQ-017 Header field: L = in_data[15:8], the code length.
REQ-018 If L>CODE_DEPTH: err=1, the block discards words until in_last is accepted, then returns to IDLE.
REQ-019 CODE: accepts L words; word i is stored to code[i] as follows:
- opcode = in_data[1:0] (0 ADD, 1 SUB, 2 DIV, 3 MUL)
- dest = in_data[7:4]
- operand1 = in_data[11:8]
- operand2 = in_data[15:12]
REQ-020 DATA: accepts NUM_REGS words into data[0..NUM_REGS-1] in order; the last one must carry in_last=1.
REQ-021 Framing check: if in_last=1 on any word other than the final data word, or in_last=0 on the final data word:
- err=1;
- the thread contents are undefined;
- the block returns to IDLE after the in_last word is accepted.
REQ-022 Correct frame: after the final data word, pc=0. The block goes to ISSUE if L>0, else directly to DRAIN.
REQ-023 in_ready=1 only in IDLE, HDR, CODE and DATA (and in discard mode).
REQ-024 exe_thread is always driven from the internal thread register. exe_instr is always driven from pc.
REQ-025 ISSUE lasts one cycle, then moves to CAPT. In CAPT:
- thread register <= exe_result;
- pc <= exe_instr_post;
- if exe_instr_post==L, go to DRAIN, else go to ISSUE.
REQ-026 Run latency is exactly 2*L cycles from leaving DATA to entering DRAIN.
REQ-027 DRAIN: out_valid=1 and out_data=data[k], for k=0..NUM_REGS-1.
REQ-028 DRAIN stepping: k advances only on a transfer. out_data holds stable while out_ready=0.
REQ-029 out_last=1 when k==NUM_REGS-1. The transfer of that word returns the block to IDLE.
REQ-030 out_valid=0 outside DRAIN.
REQ-031 pc is 8-bit and wraps modulo 256; with L<=CODE_DEPTH<=255 the wrap is unreachable in correct operation.

Reset
REQ-032 rst has priority over every handshake and over every state.
REQ-033 Reset values:
- state=IDLE, pc=0, k=0;
- thread register all zero;
- in_ready=0 during rst, then 1 in IDLE;
- out_valid=0, out_last=0, busy=0, err=0.
REQ-034 rst mid-load, mid-run or mid-drain abandons the operation with no further output words.

Verification
REQ-035 Basic run:
- stimulus: header L=1; code ADD dest=2 op1=0 op2=1; data[0]=5, data[1]=7, others 0; execution stage model attached;
- response: 2 run cycles, then 16 output words with word2=12 and out_last on word15.
REQ-036 Zero-length program:
- stimulus: L=0, data[r]=r;
- response: DRAIN entered the cycle after the final data word; output 0..15 unchanged.
REQ-037 Output backpressure:
- stimulus: out_ready toggles 1,0,0,1 during DRAIN;
- response: each word held stable while stalled; no word duplicated or lost.
REQ-038 Early in_last:
- stimulus: in_last on code word 0 of L=3;
- response: err=1, block back in IDLE, out_valid never asserted.
REQ-039 Oversize length:
- stimulus: L=17;
- response: err=1, words discarded to in_last, IDLE; the next good header clears err.
REQ-040 Mid-run reset:
- stimulus: rst asserted in CAPT of a 4-instruction run;
- response: next cycle busy=0, pc=0, out_valid=0.

Source files
------------

// File: rtl/thread_loader_if.sv
// Load and result streams of the thread loader, both valid-ready handshakes.
interface thread_loader_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    // Producer of the load stream and consumer of the result stream.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    // The thread loader itself.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/thread_loader.sv
// Thread loader: receives a program and register file over a stream, steps
// an external execution stage through the program, then streams the
// resulting registers back out.
package my_pkg;
    localparam int CODE_DEPTH = 16;
    localparam int NUM_REGS   = 16;
    localparam int DATA_W     = 32;

    typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_DIV = 2'd2, OP_MUL = 2'd3} opcode_t;

    typedef struct packed {
        opcode_t    opcode;
        logic [3:0] dest;
        logic [3:0] operand1;
        logic [3:0] operand2;
    } instr_t;

    typedef struct packed {
        instr_t [CODE_DEPTH-1:0]              code;
        logic   [NUM_REGS-1:0][DATA_W-1:0]    data;
    } thread_type;
endpackage

module thread_loader #(
    parameter int CODE_DEPTH = my_pkg::CODE_DEPTH,
    parameter int NUM_REGS   = my_pkg::NUM_REGS,
    parameter int DATA_W     = my_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    thread_loader_if.slave      bus,
    output my_pkg::thread_type  exe_thread,
    output logic [7:0]          exe_instr,
    input  my_pkg::thread_type  exe_result,
    input  logic [7:0]          exe_instr_post,
    output logic                busy,
    output logic                err
);
    localparam int CW = $clog2(CODE_DEPTH);
    localparam int RW = $clog2(NUM_REGS);
    localparam logic [RW-1:0] K_LAST   = RW'(NUM_REGS - 1);
    localparam logic [7:0]    IDX_LAST = 8'(NUM_REGS - 1);

    // HDR is the discard state: an unusable frame is swallowed up to in_last.
    typedef enum logic [2:0] {IDLE, HDR, CODE, DATA, ISSUE, CAPT, DRAIN} state_t;

    state_t             state, state_nxt;
    logic               err_nxt;
    logic [7:0]         len;
    logic [7:0]         idx;
    logic [7:0]         pc;
    logic [RW-1:0]      k;
    my_pkg::thread_type thread;
    logic               in_xfer, out_xfer;
    logic [7:0]         hdr_len;
    logic [DATA_W-1:0]  drain_word;

    function automatic my_pkg::instr_t decode(input logic [DATA_W-1:0] w);
        my_pkg::instr_t ins;
        ins.opcode   = my_pkg::opcode_t'(w[1:0]);
        ins.dest     = w[7:4];
        ins.operand1 = w[11:8];
        ins.operand2 = w[15:12];
        return ins;
    endfunction

    assign hdr_len       = bus.in_data[15:8];
    assign bus.in_ready  = !rst && (state inside {IDLE, HDR, CODE, DATA});
    assign bus.out_valid = !rst && (state == DRAIN);
    assign drain_word    = thread.data[k];
    assign bus.out_data  = drain_word;
    assign bus.out_last  = bus.out_valid && (k == K_LAST);
    assign busy          = !rst && (state != IDLE);
    assign in_xfer       = bus.in_valid && bus.in_ready;
    assign out_xfer      = bus.out_valid && bus.out_ready;
    assign exe_thread    = thread;
    assign exe_instr     = pc;

    // State and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= err_nxt;
        end
    end

    // Next-state and framing-error decision.
    always_comb begin
        state_nxt = state;
        err_nxt   = err;
        case (state)
            IDLE: begin
                if (in_xfer) begin
                    err_nxt = (hdr_len > 8'(CODE_DEPTH)) || bus.in_last;
                    if (bus.in_last)                     state_nxt = IDLE;
                    else if (hdr_len > 8'(CODE_DEPTH))   state_nxt = HDR;
                    else if (hdr_len != 8'd0)            state_nxt = CODE;
                    else                                 state_nxt = DATA;
                end
            end
            HDR: begin
                if (in_xfer && bus.in_last) state_nxt = IDLE;
            end
            CODE: begin
                if (in_xfer) begin
                    if (bus.in_last) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else if (idx == len - 8'd1) begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (in_xfer) begin
                    if (idx == IDX_LAST) begin
                        if (bus.in_last) begin
                            state_nxt = (len != 8'd0) ? ISSUE : DRAIN;
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = HDR;
                        end
                    end else if (bus.in_last) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            ISSUE: state_nxt = CAPT;
            CAPT:  state_nxt = (exe_instr_post == len) ? DRAIN : ISSUE;
            DRAIN: begin
                if (out_xfer && (k == K_LAST)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Thread register, program counter and stream indices.
    always_ff @(posedge clk) begin
        if (rst) begin
            thread <= '0;
            pc     <= 8'd0;
            k      <= '0;
            idx    <= 8'd0;
            len    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_xfer) begin
                        len <= hdr_len;
                        idx <= 8'd0;
                    end
                end
                CODE: begin
                    if (in_xfer) begin
                        thread.code[idx[CW-1:0]] <= decode(bus.in_data);
                        idx <= (idx == len - 8'd1) ? 8'd0 : idx + 8'd1;
                    end
                end
                DATA: begin
                    if (in_xfer) begin
                        thread.data[idx[RW-1:0]] <= bus.in_data;
                        idx <= idx + 8'd1;
                        if (idx == IDX_LAST) pc <= 8'd0;
                    end
                end
                CAPT: begin
                    thread <= exe_result;
                    pc     <= exe_instr_post;
                end
                DRAIN: begin
                    if (out_xfer) k <= (k == K_LAST) ? '0 : k + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_thread_loader.sv
// Directed bench for thread_loader with a one-cycle execution stage model.
module tb_thread_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    my_pkg::thread_type exe_thread, exe_result;
    logic [7:0] exe_instr, exe_instr_post;
    logic busy, err;
    int checks = 0;
    int errors = 0;
    logic [31:0] code_w [16];
    logic [31:0] data_w [16];
    logic [31:0] got_w  [16];
    logic        got_l  [16];

    thread_loader_if #(.DATA_W(32)) bus ();

    thread_loader dut (
        .clk(clk), .rst(rst), .bus(bus),
        .exe_thread(exe_thread), .exe_instr(exe_instr),
        .exe_result(exe_result), .exe_instr_post(exe_instr_post),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic my_pkg::thread_type exec(input my_pkg::thread_type th, input logic [7:0] p);
        my_pkg::thread_type t;
        my_pkg::instr_t ins;
        logic [31:0] a, b, r;
        t   = th;
        ins = th.code[p[3:0]];
        a   = th.data[ins.operand1];
        b   = th.data[ins.operand2];
        case (ins.opcode)
            my_pkg::OP_ADD: r = a + b;
            my_pkg::OP_SUB: r = a - b;
            my_pkg::OP_DIV: r = (b == 0) ? 32'd0 : a / b;
            default:        r = a * b;
        endcase
        t.data[ins.dest] = r;
        return t;
    endfunction

    // Execution stage: registered result one cycle after issue.
    always_ff @(posedge clk) begin
        exe_result     <= exec(exe_thread, exe_instr);
        exe_instr_post <= exe_instr + 8'd1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic send_frame(input int l);
        send_word(32'(l) << 8, 1'b0);
        for (int i = 0; i < l; i++) send_word(code_w[i], 1'b0);
        for (int i = 0; i < 16; i++) send_word(data_w[i], i == 15);
    endtask

    // Called just after the final data word; counts cycles until DRAIN.
    task automatic run_latency(output int n);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic drain(input bit bp);
        int k = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [31:0] held = '0;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        while (k < 16 && cyc < 200) begin
            @(negedge clk);
            bus.out_ready = bp ? pat[cyc % 4] : 1'b1;
            if (bus.out_valid) begin
                if (stalled) check("hold_stable", bus.out_data, held);
                if (bus.out_ready) begin
                    got_w[k] = bus.out_data;
                    got_l[k] = bus.out_last;
                    k++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = bus.out_data;
                end
            end
            cyc++;
        end
        if (k < 16) check("drain_timeout", k, 16);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("drain_idle_busy", busy, 0);
        check("drain_idle_valid", bus.out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit seen;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_pc", exe_instr, 0);
        check("rst_thread_zero", exe_thread == '0, 1);
        rst = 1'b0;
        #1 check("idle_in_ready", bus.in_ready, 1);
        check("idle_out_last", bus.out_last, 0);

        // Basic run: d2 = d0 + d1
        code_w[0] = 32'h1020;
        for (int i = 0; i < 16; i++) data_w[i] = 0;
        data_w[0] = 5; data_w[1] = 7;
        send_frame(1);
        check("t1_busy", busy, 1);
        run_latency(lat);
        check("t1_latency", lat, 2);
        drain(0);
        check("t1_w0", got_w[0], 5);
        check("t1_w1", got_w[1], 7);
        check("t1_w2", got_w[2], 12);
        for (int i = 3; i < 16; i++) check("t1_wrest", got_w[i], 0);
        check("t1_last14", got_l[14], 0);
        check("t1_last15", got_l[15], 1);
        check("t1_err", err, 0);

        // Early in_last on code word 0 of L=3
        send_word(32'h0300, 1'b0);
        send_word(32'h1020, 1'b1);
        check("t4_err", err, 1);
        check("t4_busy", busy, 0);
        check("t4_in_ready", bus.in_ready, 1);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        check("t4_no_out", seen, 0);

        // Oversize length: discard to in_last
        send_word(32'h1100, 1'b0);
        check("t5_err", err, 1);
        check("t5_busy_hdr", busy, 1);
        send_word(32'hAAAA, 1'b0);
        send_word(32'hBBBB, 1'b0);
        check("t5_busy_discard", busy, 1);
        send_word(32'hCCCC, 1'b1);
        check("t5_busy_done", busy, 0);
        check("t5_err_sticky", err, 1);

        // Zero-length program; its header clears err
        send_word(32'h0000, 1'b0);
        check("t2_err_cleared", err, 0);
        for (int i = 0; i < 16; i++) send_word(32'(i), i == 15);
        run_latency(lat);
        check("t2_latency", lat, 0);
        drain(0);
        for (int i = 0; i < 16; i++) check("t2_word", got_w[i], i);
        check("t2_last", got_l[15], 1);

        // Missing in_last on final data word
        send_word(32'h0000, 1'b0);
        for (int i = 0; i < 16; i++) send_word(32'(i), 1'b0);
        check("tm_err", err, 1);
        check("tm_busy_discard", busy, 1);
        send_word(32'h1234, 1'b1);
        check("tm_busy_done", busy, 0);

        // Backpressure with L=2: d3 = d1 - d0 = 2, d4 = d3 * d1 = 14
        code_w[0] = 32'h0131;
        code_w[1] = 32'h1343;
        for (int i = 0; i < 16; i++) data_w[i] = 32'(100 + i);
        data_w[0] = 5; data_w[1] = 7;
        send_frame(2);
        check("t3_err", err, 0);
        run_latency(lat);
        check("t3_latency", lat, 4);
        drain(1);
        check("t3_w0", got_w[0], 5);
        check("t3_w1", got_w[1], 7);
        check("t3_w2", got_w[2], 102);
        check("t3_w3", got_w[3], 2);
        check("t3_w4", got_w[4], 14);
        for (int i = 5; i < 16; i++) check("t3_wrest", got_w[i], 100 + i);
        check("t3_last", got_l[15], 1);

        // Reset in the second CAPT of a 4-instruction run
        for (int i = 0; i < 4; i++) code_w[i] = 32'h1020;
        send_frame(4);
        repeat (3) @(posedge clk);
        #1;
        check("t6_pc_capt", exe_instr, 1);
        check("t6_busy_run", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_busy", busy, 0);
        check("t6_pc", exe_instr, 0);
        check("t6_out_valid", bus.out_valid, 0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        check("t6_no_out", seen, 0);
        check("t6_in_ready", bus.in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
